// File: rtl/nic_pwr_stagger_arbiter.sv
// Round-robin slot power sequencer: one NIC slot powers up at a time, with a
// power-good timeout and a fixed stagger gap. Optional macro: NIC_STAGGER_PRSNT_MASK_EN.
module nic_pwr_stagger_arbiter #(
   parameter int NUM_SLOTS  = 2,
   parameter int STAGGER_MS = 4,
   parameter int TIMEOUT_MS = 20
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic                 iTick_1ms,
   input  logic [NUM_SLOTS-1:0] iReq,
   input  logic [NUM_SLOTS-1:0] iPwrgd,
`ifdef NIC_STAGGER_PRSNT_MASK_EN
   input  logic [NUM_SLOTS-1:0] iPRSNT_N,
`endif
   output logic [NUM_SLOTS-1:0] oPwrEn,
   output logic [NUM_SLOTS-1:0] oFault,
   output logic                 oAllPwrOk,
   output logic                 oBusy,
   output logic [1:0]           oFsmState
);

   localparam int MAXV = (STAGGER_MS > TIMEOUT_MS) ? STAGGER_MS : TIMEOUT_MS;
   localparam int CW   = $clog2(MAXV + 1);
   localparam int PW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e               state_q;
   logic [NUM_SLOTS-1:0] en_q;
   logic [NUM_SLOTS-1:0] fault_q;
   logic [NUM_SLOTS-1:0] done_q;
   logic [PW-1:0]        ptr_q;
   logic [CW-1:0]        cnt_q;
   logic                 all_ok_q;

   logic [NUM_SLOTS-1:0] req_eff;
   logic [NUM_SLOTS-1:0] pend;
   logic [PW-1:0]        sel_d;
   logic [PW-1:0]        idx;
   logic                 found;
   logic                 all_ok_d;

   // Level handshake: a slot holds iReq while it wants power; the arbiter answers
   // with oPwrEn and the slot returns iPwrgd. Dropping iReq withdraws and clears state.
`ifdef NIC_STAGGER_PRSNT_MASK_EN
   assign req_eff = iReq & ~iPRSNT_N;
`else
   assign req_eff = iReq;
`endif

   assign pend = req_eff & ~done_q & ~fault_q;

   // First pending slot after the last granted one, wrapping around.
   always_comb begin
      sel_d = ptr_q;
      idx   = ptr_q;
      found = 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         idx = (idx == PW'(NUM_SLOTS - 1)) ? '0 : idx + PW'(1);
         if (!found && pend[idx]) begin
            sel_d = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      all_ok_d = (state_q == ST_IDLE) && (pend == '0) && (req_eff != '0) &&
                 ((req_eff & ~(done_q & iPwrgd)) == '0);
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q  <= ST_IDLE;
         en_q     <= '0;
         fault_q  <= '0;
         done_q   <= '0;
         ptr_q    <= PW'(NUM_SLOTS - 1);
         cnt_q    <= '0;
         all_ok_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pend != '0) begin
                  en_q[sel_d] <= 1'b1;
                  ptr_q       <= sel_d;
                  cnt_q       <= '0;
                  state_q     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (iTick_1ms && (cnt_q != CW'(TIMEOUT_MS)))
                  cnt_q <= cnt_q + CW'(1);
               // Withdrawal beats power-good, which beats the timeout tick.
               if (!req_eff[ptr_q]) begin
                  cnt_q   <= '0;
                  state_q <= ST_GAP;
               end else if (iPwrgd[ptr_q]) begin
                  done_q[ptr_q] <= 1'b1;
                  cnt_q         <= '0;
                  state_q       <= ST_GAP;
               end else if (iTick_1ms && (cnt_q == CW'(TIMEOUT_MS - 1))) begin
                  fault_q[ptr_q] <= 1'b1;
                  en_q[ptr_q]    <= 1'b0;
                  cnt_q          <= '0;
                  state_q        <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (iTick_1ms) begin
                  if (cnt_q == CW'(STAGGER_MS - 1))
                     state_q <= ST_IDLE;
                  else if (cnt_q != CW'(STAGGER_MS))
                     cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         // A released slot is wiped in every state; this is the only fault clear.
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!req_eff[i]) begin
               en_q[i]    <= 1'b0;
               done_q[i]  <= 1'b0;
               fault_q[i] <= 1'b0;
            end
         end
         all_ok_q <= all_ok_d;
      end
   end

   assign oPwrEn    = en_q;
   assign oFault    = fault_q;
   assign oAllPwrOk = all_ok_q;
   assign oBusy     = (state_q != ST_IDLE);
   assign oFsmState = state_q;

endmodule

// File: tb/tb_nic_pwr_stagger_arbiter.sv
// Directed bench for nic_pwr_stagger_arbiter (2 slots, 4 ms stagger, 10 ms timeout).
module tb_nic_pwr_stagger_arbiter;

   logic       iClk = 1'b0;
   logic       iRst_n;
   logic       iTick_1ms;
   logic [1:0] iReq;
   logic [1:0] iPwrgd;
`ifdef NIC_STAGGER_PRSNT_MASK_EN
   logic [1:0] iPRSNT_N;
`endif
   logic [1:0] oPwrEn;
   logic [1:0] oFault;
   logic       oAllPwrOk;
   logic       oBusy;
   logic [1:0] oFsmState;

   int n_vec = 0;
   int n_err = 0;

   always #5 iClk = ~iClk;

   nic_pwr_stagger_arbiter #(
      .NUM_SLOTS (2),
      .STAGGER_MS(4),
      .TIMEOUT_MS(10)
   ) dut (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iTick_1ms(iTick_1ms),
      .iReq     (iReq),
      .iPwrgd   (iPwrgd),
`ifdef NIC_STAGGER_PRSNT_MASK_EN
      .iPRSNT_N (iPRSNT_N),
`endif
      .oPwrEn   (oPwrEn),
      .oFault   (oFault),
      .oAllPwrOk(oAllPwrOk),
      .oBusy    (oBusy),
      .oFsmState(oFsmState)
   );

   task automatic step(input int n);
      repeat (n) @(negedge iClk);
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         iTick_1ms = 1'b1;
         @(negedge iClk);
         iTick_1ms = 1'b0;
         @(negedge iClk);
      end
   endtask

   task automatic test_reset;
      iRst_n = 1'b0; iReq = 2'b00; iPwrgd = 2'b00; iTick_1ms = 1'b0;
      step(3);
      n_vec++; if (oPwrEn !== 2'b00) begin n_err++; $display("FAIL rst_en: got %b exp 00", oPwrEn); end
      n_vec++; if (oFault !== 2'b00) begin n_err++; $display("FAIL rst_fault: got %b exp 00", oFault); end
      n_vec++; if (oAllPwrOk !== 1'b0) begin n_err++; $display("FAIL rst_allok: got %b exp 0", oAllPwrOk); end
      n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", oBusy); end
      n_vec++; if (oFsmState !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d exp 0", oFsmState); end
      iRst_n = 1'b1;
      step(2);
      n_vec++; if (oAllPwrOk !== 1'b0) begin n_err++; $display("FAIL rst_noreq_allok: got %b exp 0", oAllPwrOk); end
      n_vec++; if (oFsmState !== 2'd0) begin n_err++; $display("FAIL rst_idle_state: got %0d exp 0", oFsmState); end
   endtask

   task automatic test_stagger_sequence;
      iReq = 2'b11;
      step(1);
      n_vec++; if (oPwrEn !== 2'b01) begin n_err++; $display("FAIL seq_grant0_en: got %b exp 01", oPwrEn); end
      n_vec++; if (oFsmState !== 2'd1) begin n_err++; $display("FAIL seq_grant0_state: got %0d exp 1", oFsmState); end
      n_vec++; if (oBusy !== 1'b1) begin n_err++; $display("FAIL seq_busy: got %b exp 1", oBusy); end
      tick_n(3);
      n_vec++; if (oFsmState !== 2'd1) begin n_err++; $display("FAIL seq_wait_state: got %0d exp 1", oFsmState); end
      iPwrgd = 2'b01;
      step(1);
      n_vec++; if (oFsmState !== 2'd2) begin n_err++; $display("FAIL seq_gap0_state: got %0d exp 2", oFsmState); end
      tick_n(3);
      n_vec++; if (oPwrEn !== 2'b01) begin n_err++; $display("FAIL seq_gap0_en: got %b exp 01", oPwrEn); end
      n_vec++; if (oFsmState !== 2'd2) begin n_err++; $display("FAIL seq_gap0_hold: got %0d exp 2", oFsmState); end
      n_vec++; if (oAllPwrOk !== 1'b0) begin n_err++; $display("FAIL seq_gap_allok: got %b exp 0", oAllPwrOk); end
      tick_n(1);
      n_vec++; if (oPwrEn !== 2'b11) begin n_err++; $display("FAIL seq_grant1_en: got %b exp 11", oPwrEn); end
      n_vec++; if (oFsmState !== 2'd1) begin n_err++; $display("FAIL seq_grant1_state: got %0d exp 1", oFsmState); end
      iPwrgd = 2'b11;
      step(1);
      n_vec++; if (oFsmState !== 2'd2) begin n_err++; $display("FAIL seq_gap1_state: got %0d exp 2", oFsmState); end
      tick_n(4);
      n_vec++; if (oAllPwrOk !== 1'b1) begin n_err++; $display("FAIL seq_allok: got %b exp 1", oAllPwrOk); end
      n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL seq_idle_busy: got %b exp 0", oBusy); end
      n_vec++; if (oPwrEn !== 2'b11) begin n_err++; $display("FAIL seq_final_en: got %b exp 11", oPwrEn); end
   endtask

   task automatic test_timeout;
      iReq = 2'b00; iPwrgd = 2'b00;
      step(2);
      n_vec++; if (oPwrEn !== 2'b00) begin n_err++; $display("FAIL to_release_en: got %b exp 00", oPwrEn); end
      iReq = 2'b01;
      step(1);
      n_vec++; if (oPwrEn !== 2'b01) begin n_err++; $display("FAIL to_grant_en: got %b exp 01", oPwrEn); end
      tick_n(9);
      n_vec++; if (oFault !== 2'b00) begin n_err++; $display("FAIL to_early_fault: got %b exp 00", oFault); end
      n_vec++; if (oPwrEn !== 2'b01) begin n_err++; $display("FAIL to_early_en: got %b exp 01", oPwrEn); end
      tick_n(1);
      n_vec++; if (oFault !== 2'b01) begin n_err++; $display("FAIL to_fault: got %b exp 01", oFault); end
      n_vec++; if (oPwrEn !== 2'b00) begin n_err++; $display("FAIL to_fault_en: got %b exp 00", oPwrEn); end
      n_vec++; if (oFsmState !== 2'd2) begin n_err++; $display("FAIL to_gap_state: got %0d exp 2", oFsmState); end
      iReq = 2'b00;
      step(1);
      n_vec++; if (oFault !== 2'b00) begin n_err++; $display("FAIL to_fault_clear: got %b exp 00", oFault); end
      tick_n(4);
      n_vec++; if (oFsmState !== 2'd0) begin n_err++; $display("FAIL to_idle_state: got %0d exp 0", oFsmState); end
   endtask

   task automatic test_fairness;
      iReq = 2'b10;
      step(1);
      n_vec++; if (oPwrEn !== 2'b10) begin n_err++; $display("FAIL rr_grant1_en: got %b exp 10", oPwrEn); end
      iPwrgd = 2'b10;
      step(1);
      tick_n(4);
      n_vec++; if (oAllPwrOk !== 1'b1) begin n_err++; $display("FAIL rr_slot1_allok: got %b exp 1", oAllPwrOk); end
      iReq = 2'b00; iPwrgd = 2'b00;
      step(2);
      iReq = 2'b11;
      step(1);
      n_vec++; if (oPwrEn !== 2'b01) begin n_err++; $display("FAIL rr_slot0_first: got %b exp 01", oPwrEn); end
   endtask

   task automatic test_req_drop;
      iPwrgd = 2'b01;
      step(1);
      tick_n(4);
      n_vec++; if (oPwrEn !== 2'b11) begin n_err++; $display("FAIL drop_grant1_en: got %b exp 11", oPwrEn); end
      tick_n(2);
      iReq = 2'b01;
      step(1);
      n_vec++; if (oPwrEn !== 2'b01) begin n_err++; $display("FAIL drop_en: got %b exp 01", oPwrEn); end
      n_vec++; if (oFsmState !== 2'd2) begin n_err++; $display("FAIL drop_gap_state: got %0d exp 2", oFsmState); end
      n_vec++; if (oFault !== 2'b00) begin n_err++; $display("FAIL drop_fault: got %b exp 00", oFault); end
      tick_n(3);
      n_vec++; if (oFsmState !== 2'd2) begin n_err++; $display("FAIL drop_gap_hold: got %0d exp 2", oFsmState); end
      tick_n(1);
      n_vec++; if (oFsmState !== 2'd0) begin n_err++; $display("FAIL drop_idle_state: got %0d exp 0", oFsmState); end
      n_vec++; if (oAllPwrOk !== 1'b1) begin n_err++; $display("FAIL drop_allok: got %b exp 1", oAllPwrOk); end
   endtask

   task automatic test_reset_mid_gap;
      iReq = 2'b11;
      step(1);
      n_vec++; if (oPwrEn !== 2'b11) begin n_err++; $display("FAIL rg_grant1_en: got %b exp 11", oPwrEn); end
      iPwrgd = 2'b11;
      step(1);
      n_vec++; if (oFsmState !== 2'd2) begin n_err++; $display("FAIL rg_gap_state: got %0d exp 2", oFsmState); end
      iRst_n = 1'b0;
      #1;
      n_vec++; if (oPwrEn !== 2'b00) begin n_err++; $display("FAIL rg_async_en: got %b exp 00", oPwrEn); end
      n_vec++; if (oFsmState !== 2'd0) begin n_err++; $display("FAIL rg_async_state: got %0d exp 0", oFsmState); end
      n_vec++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL rg_async_busy: got %b exp 0", oBusy); end
      n_vec++; if (oAllPwrOk !== 1'b0) begin n_err++; $display("FAIL rg_async_allok: got %b exp 0", oAllPwrOk); end
      iPwrgd = 2'b00;
      step(1);
      iRst_n = 1'b1;
      step(1);
      n_vec++; if (oPwrEn !== 2'b01) begin n_err++; $display("FAIL rg_slot0_first: got %b exp 01", oPwrEn); end
   endtask

`ifdef NIC_STAGGER_PRSNT_MASK_EN
   task automatic test_prsnt_mask;
      iRst_n = 1'b0; iReq = 2'b00; iPwrgd = 2'b00; iPRSNT_N = 2'b10;
      step(2);
      iRst_n = 1'b1;
      step(1);
      iReq = 2'b11;
      step(1);
      n_vec++; if (oPwrEn !== 2'b01) begin n_err++; $display("FAIL prs_grant0_en: got %b exp 01", oPwrEn); end
      iPwrgd = 2'b01;
      step(1);
      tick_n(4);
      n_vec++; if (oAllPwrOk !== 1'b1) begin n_err++; $display("FAIL prs_allok: got %b exp 1", oAllPwrOk); end
      step(3);
      n_vec++; if (oPwrEn !== 2'b01) begin n_err++; $display("FAIL prs_slot1_never: got %b exp 01", oPwrEn); end
      n_vec++; if (oFsmState !== 2'd0) begin n_err++; $display("FAIL prs_idle_state: got %0d exp 0", oFsmState); end
   endtask
`endif

   initial begin
      iRst_n = 1'b0; iTick_1ms = 1'b0; iReq = 2'b00; iPwrgd = 2'b00;
`ifdef NIC_STAGGER_PRSNT_MASK_EN
      iPRSNT_N = 2'b00;
`endif
      test_reset();
      test_stagger_sequence();
      test_timeout();
      test_fairness();
      test_req_drop();
      test_reset_mid_gap();
`ifdef NIC_STAGGER_PRSNT_MASK_EN
      test_prsnt_mask();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
